// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, LSB first, WIDTH+1 cycles per result plus one DONE cycle.
// Optional signed-overflow output Ovf is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y,
  output logic             Co
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, y_q, y_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d, co_q, co_d;
  logic             sum_bit, carry_bit, last_bit;

  assign sum_bit   = a_q[0] ^ b_q[0] ^ c_q;
  assign carry_bit = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
  assign last_bit  = (cnt_q == CW'(WIDTH - 1));

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    co_d    = co_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          c_d     = Ci;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = carry_bit;
        res_d = {sum_bit, res_q[WIDTH-1:1]};
        if (last_bit) begin
          // Outputs are published only here so partial sums never reach Y.
          y_d     = {sum_bit, res_q[WIDTH-1:1]};
          co_d    = carry_bit;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = c_q ^ carry_bit;
`endif
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      res_q   <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      co_q    <= co_d;
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign Ovf = ovf_q;
`endif

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign Y    = y_q;
  assign Co   = co_q;

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 A  input  WIDTH  operand A; sampled on the accepting edge only.
REQ-006 B  input  WIDTH  operand B; sampled on the accepting edge only.
REQ-007 Ci  input  1  initial carry-in; sampled on the accepting edge only.
REQ-008 busy  output  1  high while an addition is in progress (RUN or DONE).
REQ-009 done  output  1  one-cycle pulse; Y and Co are valid from this cycle onward.
REQ-010 Y  output  WIDTH  sum A+B+Ci modulo 2^WIDTH.
REQ-011 Co  output  1  carry out of bit WIDTH-1.

Function
REQ-012 Bit-serial datapath: one full-adder cell (sum = a^b^c, carry = majority(a,b,c)); exactly one bit processed per clock, LSB first.
REQ-013 FSM states: IDLE, RUN, DONE; no other states are reachable.
REQ-014 IDLE: when start=1 at an edge -> load A and B into shift registers, carry register <= Ci, bit counter <= 0, next state RUN; when start=0 -> remain in IDLE.
REQ-015 RUN: each edge adds the LSBs of both shift registers plus the carry register; the sum bit shifts into the result register from the MSB side; the carry register takes the cell carry; the operand registers shift right by 1; the counter increments.
REQ-016 RUN -> DONE on the edge that processes bit WIDTH-1 (counter = WIDTH-1); the counter never exceeds WIDTH-1.
REQ-017 DONE: done=1 for exactly one cycle; Y = result register; Co = carry register; next state is IDLE unconditionally.
REQ-018 Latency: with start accepted at edge N, done is high in the cycle following edge N+WIDTH; back-to-back throughput is one result per WIDTH+2 cycles.
REQ-019 busy = 1 in RUN and DONE, 0 in IDLE; start while busy=1 (including in the DONE cycle) is ignored and is not queued.
REQ-020 Y and Co hold their last result through IDLE and change only when the next DONE is reached; intermediate partial sums are never visible on Y.
REQ-021 Changes on A, B or Ci after the accepting edge have no effect on the result in progress.

Reset
REQ-022 reset=1 forces, asynchronously: state=IDLE, busy=0, done=0, Y=0, Co=0, and clears the counter, carry and shift registers.
REQ-023 Reset asserted mid-RUN or in DONE aborts the operation; no done pulse follows, and the first start after reset release is accepted normally.

Configuration
REQ-024 Macro SERIAL_ADDER_OVF_EN: when defined, an extra port Ovf (output, 1 bit) reports two's-complement signed overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, captured at the bit WIDTH-1 edge and held/updated with the same timing as Co, reset to 0.
REQ-025 When SERIAL_ADDER_OVF_EN is undefined, the Ovf port and its logic do not exist; all other behaviour is identical.

Verification (WIDTH=8)
REQ-026 A=8'h0F, B=8'h01, Ci=0, start pulse -> done high 9 edges later, Y=8'h10, Co=0.
REQ-027 A=8'hFF, B=8'h01, Ci=0 -> Y=8'h00, Co=1; then A=8'hFF, B=8'hFF, Ci=1 -> Y=8'hFF, Co=1.
REQ-028 start held high continuously, A=8'h01, B=8'h02 -> done pulses every 10 cycles, Y=8'h03 each time; operands changed to A=8'h55 while busy do not affect the result in flight.
REQ-029 reset pulsed 4 cycles after start -> busy=0, Y=0, Co=0, no done pulse; the next start with A=8'h20, B=8'h22 gives Y=8'h42.
REQ-030 Random A, B, Ci for 16 iterations -> {Co,Y} == A+B+Ci at each done; with SERIAL_ADDER_OVF_EN defined, A=8'h7F, B=8'h01 gives Ovf=1, and A=8'h80, B=8'h80 gives Ovf=1, Co=1.
